// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S constants and types
package i2s_pkg;

  // Word-select encoding on the ws pin
  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

  // Default sample depth, slot width and sck half-period divider
  localparam int B_DEF   = 16;
  localparam int W_DEF   = 16;
  localparam int DIV_DEF = 2;

  // Bit-period counter width: 2*w <= 64 always fits in 6 bits
  localparam int PW = 6;
  typedef logic [PW-1:0] pcnt_t;

endpackage

// File: rtl/i2s_sck_gen.sv
// rtl/i2s_sck_gen.sv - sck divider with fall-event strobe
module i2s_sck_gen
  import i2s_pkg::*;
#(
  parameter int div = DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic sck,
  output logic fall
);

  localparam int DW = (div > 1) ? $clog2(div) : 1;
  localparam logic [DW-1:0] DC_LAST = DW'(div - 1);

  logic [DW-1:0] dc;
  logic          tgl;

  // sck toggles at the end of each half-period; fall marks the 1->0 toggle
  assign tgl  = (dc == DC_LAST);
  assign fall = tgl & sck;

  // Half-period counter and sck register
  always_ff @(posedge clk) begin
    if (rst) begin
      dc  <= '0;
      sck <= 1'b0;
    end else if (tgl) begin
      dc  <= '0;
      sck <= ~sck;
    end else begin
      dc  <= dc + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - I2S master transmitter; I2S_TX_MUTE_EN sends silence on underrun
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int b   = B_DEF,
  parameter int w   = W_DEF,
  parameter int div = DIV_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [b-1:0] l,
  input  logic [b-1:0] r,
  input  logic         stb,
  output logic         rdy,
  output logic         ld,
  output logic         sck,
  output logic         ws,
  output logic         sd
);

  localparam pcnt_t P_LAST = pcnt_t'(2 * w - 1);
  localparam pcnt_t WS_LO  = pcnt_t'(w - 1);
  localparam pcnt_t WS_HI  = pcnt_t'(2 * w - 2);
  localparam pcnt_t W6     = pcnt_t'(w);
  localparam pcnt_t B6     = pcnt_t'(b);

  logic         fall;
  logic         full;
  logic [b-1:0] hl, hr, sl, sr;
  pcnt_t        p;

  logic         load, acc, ld_n, ws_n, sd_n;
  pcnt_t        pn, q;
  logic [b-1:0] sl_n, sr_n, lsh, rsh;

  i2s_sck_gen #(.div(div)) u_sck (
    .clk  (clk),
    .rst  (rst),
    .sck  (sck),
    .fall (fall)
  );

  assign rdy = ~full;
  assign acc = stb & ~full;

  // Next bit position, frame load decision and the bit/ws to present after the fall
  always_comb begin
    pn   = (p == P_LAST) ? '0 : p + 1'b1;
    q    = pn - W6;
    load = fall && (p == P_LAST);
    sl_n = sl;
    sr_n = sr;
    ld_n = 1'b0;
    if (load) begin
      if (full) begin
        sl_n = hl;
        sr_n = hr;
        ld_n = 1'b1;
      end else begin
`ifdef I2S_TX_MUTE_EN
        sl_n = '0;
        sr_n = '0;
`else
        sl_n = sl;
        sr_n = sr;
`endif
      end
    end
    ws_n = ((pn >= WS_LO) && (pn <= WS_HI)) ? WS_RIGHT : WS_LEFT;
    lsh  = sl_n << pn;
    rsh  = sr_n << q;
    sd_n = 1'b0;
    if (pn < W6) begin
      if (pn < B6) sd_n = lsh[b-1];
    end else begin
      if (q < B6) sd_n = rsh[b-1];
    end
  end

  // Holding buffer, shift registers, bit counter and pin registers
  always_ff @(posedge clk) begin
    if (rst) begin
      p    <= P_LAST;
      ws   <= 1'b0;
      sd   <= 1'b0;
      ld   <= 1'b0;
      full <= 1'b0;
      hl   <= '0;
      hr   <= '0;
      sl   <= '0;
      sr   <= '0;
    end else begin
      if (fall) begin
        p  <= pn;
        ws <= ws_n;
        sd <= sd_n;
      end
      sl <= sl_n;
      sr <= sr_n;
      ld <= ld_n;
      // Buffer frees one clk after the load pulse
      if (ld) full <= 1'b0;
      if (acc) begin
        hl   <= l;
        hr   <= r;
        full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// tb/tb_i2s_tx.sv - directed bench for i2s_tx (w=16 and w=24 instances)
module tb_i2s_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0, stb24 = 1'b0;
  logic [15:0] l = '0, r = '0, l24 = '0, r24 = '0;
  logic        rdy, ld, sck, ws, sd;
  logic        rdy24, ld24, sck24, ws24, sd24;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  i2s_tx #(.b(16), .w(16), .div(2)) dut (
    .clk(clk), .rst(rst), .l(l), .r(r), .stb(stb), .rdy(rdy),
    .ld(ld), .sck(sck), .ws(ws), .sd(sd)
  );

  i2s_tx #(.b(16), .w(24), .div(2)) dut24 (
    .clk(clk), .rst(rst), .l(l24), .r(r24), .stb(stb24), .rdy(rdy24),
    .ld(ld24), .sck(sck24), .ws(ws24), .sd(sd24)
  );

  // Frame recorders: rise n (n>=2) after reset samples bit position p=(n-2) mod 2w
  int          n0, n24, ldc0, ldc24;
  logic        sp0, sp24;
  logic [63:0] frm0 [0:3];
  logic [63:0] wsf0 [0:3];
  logic [63:0] frm24 [0:3];
  logic [63:0] wsf24 [0:3];

  always @(negedge clk) begin
    if (rst) begin
      n0 = 0; ldc0 = 0; sp0 = 1'b0;
      for (int i = 0; i < 4; i++) begin frm0[i] = '0; wsf0[i] = '0; end
    end else begin
      if (ld) ldc0++;
      if (sck && !sp0) begin
        n0++;
        if (n0 >= 2 && (n0 - 2) / 32 < 4) begin
          frm0[(n0 - 2) / 32] = frm0[(n0 - 2) / 32] | (64'(sd) << (31 - (n0 - 2) % 32));
          wsf0[(n0 - 2) / 32] = wsf0[(n0 - 2) / 32] | (64'(ws) << (31 - (n0 - 2) % 32));
        end
      end
      sp0 = sck;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      n24 = 0; ldc24 = 0; sp24 = 1'b0;
      for (int i = 0; i < 4; i++) begin frm24[i] = '0; wsf24[i] = '0; end
    end else begin
      if (ld24) ldc24++;
      if (sck24 && !sp24) begin
        n24++;
        if (n24 >= 2 && (n24 - 2) / 48 < 4) begin
          frm24[(n24 - 2) / 48] = frm24[(n24 - 2) / 48] | (64'(sd24) << (47 - (n24 - 2) % 48));
          wsf24[(n24 - 2) / 48] = wsf24[(n24 - 2) / 48] | (64'(ws24) << (47 - (n24 - 2) % 48));
        end
      end
      sp24 = sck24;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    stb = 1'b0; stb24 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_rises(input bit sel, input int target, input string name);
    int k = 0;
    while (((sel ? n24 : n0) < target) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    total++;
    if ((sel ? n24 : n0) < target) begin
      bad++;
      $display("FAIL %s timeout: rises=%0d need=%0d", name, sel ? n24 : n0, target);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total += 5;
    if (sck !== 1'b0) begin bad++; $display("FAIL reset_sck got=%b want=0", sck); end
    if (ws  !== 1'b0) begin bad++; $display("FAIL reset_ws got=%b want=0", ws); end
    if (sd  !== 1'b0) begin bad++; $display("FAIL reset_sd got=%b want=0", sd); end
    if (rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b want=1", rdy); end
    if (ld  !== 1'b0) begin bad++; $display("FAIL reset_ld got=%b want=0", ld); end
  endtask

  task automatic test_frame();
    do_reset();
    stb = 1'b1; l = 16'hA5C3; r = 16'h0F0F;
    @(negedge clk);
    stb = 1'b0;
    total += 2;
    if (rdy !== 1'b0) begin bad++; $display("FAIL frame_rdy_accept got=%b want=0", rdy); end
    if (sck !== 1'b0) begin bad++; $display("FAIL frame_sck_c1 got=%b want=0", sck); end
    @(negedge clk);
    total++;
    if (sck !== 1'b1) begin bad++; $display("FAIL frame_sck_rise_c2 got=%b want=1", sck); end
    @(negedge clk);
    total += 2;
    if (sck !== 1'b1) begin bad++; $display("FAIL frame_sck_c3 got=%b want=1", sck); end
    if (ld  !== 1'b0) begin bad++; $display("FAIL frame_ld_c3 got=%b want=0", ld); end
    @(negedge clk);
    total += 5;
    if (sck !== 1'b0) begin bad++; $display("FAIL frame_sck_fall_c4 got=%b want=0", sck); end
    if (ld  !== 1'b1) begin bad++; $display("FAIL frame_ld_c4 got=%b want=1", ld); end
    if (rdy !== 1'b0) begin bad++; $display("FAIL frame_rdy_c4 got=%b want=0", rdy); end
    if (ws  !== 1'b0) begin bad++; $display("FAIL frame_ws_c4 got=%b want=0", ws); end
    if (sd  !== 1'b1) begin bad++; $display("FAIL frame_sd_msb_c4 got=%b want=1", sd); end
    @(negedge clk);
    total += 2;
    if (ld  !== 1'b0) begin bad++; $display("FAIL frame_ld_c5 got=%b want=0", ld); end
    if (rdy !== 1'b1) begin bad++; $display("FAIL frame_rdy_c5 got=%b want=1", rdy); end
    wait_rises(1'b0, 34, "frame");
    total += 3;
    if (frm0[0] !== 64'h0000_0000_A5C3_0F0F) begin bad++; $display("FAIL frame_data got=%h want=%h", frm0[0], 64'hA5C30F0F); end
    if (wsf0[0] !== 64'h0000_0000_0001_FFFE) begin bad++; $display("FAIL frame_ws got=%h want=%h", wsf0[0], 64'h0001FFFE); end
    if (ldc0 !== 1) begin bad++; $display("FAIL frame_ld_count got=%0d want=1", ldc0); end
  endtask

  task automatic test_padding();
    do_reset();
    stb24 = 1'b1; l24 = 16'h8001; r24 = 16'hFFFF;
    @(negedge clk);
    stb24 = 1'b0;
    wait_rises(1'b1, 50, "padding");
    total += 3;
    if (frm24[0] !== 64'h0000_8001_00FF_FF00) begin bad++; $display("FAIL pad_data got=%h want=%h", frm24[0], 64'h800100FFFF00); end
    if (wsf24[0] !== 64'h0000_0000_01FF_FFFE) begin bad++; $display("FAIL pad_ws got=%h want=%h", wsf24[0], 64'h01FFFFFE); end
    if (ldc24 !== 1) begin bad++; $display("FAIL pad_ld_count got=%0d want=1", ldc24); end
  endtask

  task automatic test_underrun();
    logic [63:0] exp1;
`ifdef I2S_TX_MUTE_EN
    exp1 = 64'h0;
`else
    exp1 = 64'h1234_5678;
`endif
    do_reset();
    stb = 1'b1; l = 16'h1234; r = 16'h5678;
    @(negedge clk);
    stb = 1'b0;
    wait_rises(1'b0, 66, "underrun");
    total += 3;
    if (frm0[0] !== 64'h1234_5678) begin bad++; $display("FAIL under_f0 got=%h want=%h", frm0[0], 64'h12345678); end
    if (frm0[1] !== exp1) begin bad++; $display("FAIL under_f1 got=%h want=%h", frm0[1], exp1); end
    if (ldc0 !== 1) begin bad++; $display("FAIL under_ld_count got=%0d want=1", ldc0); end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp1;
`ifdef I2S_TX_MUTE_EN
    exp1 = 64'h0;
`else
    exp1 = 64'h1111_2222;
`endif
    do_reset();
    stb = 1'b1; l = 16'h1111; r = 16'h2222;
    @(negedge clk);
    l = 16'h3333; r = 16'h4444;
    @(negedge clk);
    l = 16'h5555; r = 16'h6666;
    @(negedge clk);
    stb = 1'b0;
    wait_rises(1'b0, 66, "backpressure");
    total += 3;
    if (frm0[0] !== 64'h1111_2222) begin bad++; $display("FAIL bp_f0 got=%h want=%h", frm0[0], 64'h11112222); end
    if (frm0[1] !== exp1) begin bad++; $display("FAIL bp_f1 got=%h want=%h", frm0[1], exp1); end
    if (ldc0 !== 1) begin bad++; $display("FAIL bp_ld_count got=%0d want=1", ldc0); end
  endtask

  task automatic test_load_collision();
    do_reset();
    repeat (3) @(negedge clk);
    stb = 1'b1; l = 16'hABCD; r = 16'h1357;
    @(negedge clk);
    stb = 1'b0;
    total += 3;
    if (sck !== 1'b0) begin bad++; $display("FAIL coll_sck got=%b want=0", sck); end
    if (ld  !== 1'b0) begin bad++; $display("FAIL coll_ld got=%b want=0", ld); end
    if (rdy !== 1'b0) begin bad++; $display("FAIL coll_rdy got=%b want=0", rdy); end
    wait_rises(1'b0, 66, "collision");
    total += 3;
    if (frm0[0] !== 64'h0) begin bad++; $display("FAIL coll_f0 got=%h want=0", frm0[0]); end
    if (frm0[1] !== 64'hABCD_1357) begin bad++; $display("FAIL coll_f1 got=%h want=%h", frm0[1], 64'hABCD1357); end
    if (ldc0 !== 1) begin bad++; $display("FAIL coll_ld_count got=%0d want=1", ldc0); end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    stb = 1'b1; l = 16'hFFFF; r = 16'hFFFF;
    @(negedge clk);
    stb = 1'b0;
    repeat (5) @(negedge clk);
    stb = 1'b1; l = 16'h7E7E; r = 16'h8181;
    @(negedge clk);
    stb = 1'b0;
    wait_rises(1'b0, 9, "midframe_p7");
    total++;
    if (rdy !== 1'b0) begin bad++; $display("FAIL mid_rdy_held got=%b want=0", rdy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total += 5;
    if (sck !== 1'b0) begin bad++; $display("FAIL mid_sck got=%b want=0", sck); end
    if (ws  !== 1'b0) begin bad++; $display("FAIL mid_ws got=%b want=0", ws); end
    if (sd  !== 1'b0) begin bad++; $display("FAIL mid_sd got=%b want=0", sd); end
    if (rdy !== 1'b1) begin bad++; $display("FAIL mid_rdy got=%b want=1", rdy); end
    if (ld  !== 1'b0) begin bad++; $display("FAIL mid_ld got=%b want=0", ld); end
    wait_rises(1'b0, 34, "midframe_after");
    total += 2;
    if (frm0[0] !== 64'h0) begin bad++; $display("FAIL mid_f0 got=%h want=0", frm0[0]); end
    if (ldc0 !== 0) begin bad++; $display("FAIL mid_ld_count got=%0d want=0", ldc0); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_padding();
    test_underrun();
    test_backpressure();
    test_load_collision();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
